// File: rtl/ks_pkg.sv
// ks_pkg: shared state encoding, default widths and SRAM strobe levels for the
// keystream reader.
package ks_pkg;

  localparam int KS_ADDR_W = 18;
  localparam int KS_DATA_W = 16;

  // SRAM control strobes are all active-low
  localparam logic SRAM_ASSERT   = 1'b0;
  localparam logic SRAM_DEASSERT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ACC = 3'd1,
    ST_XFER   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } ks_state_e;

endpackage

// File: rtl/ks_sram_rd.sv
// ks_sram_rd: SRAM read timing. Holds oe_n low for RD_WAIT cycles per word and
// captures sram_dq into a one-entry key register that the consumer drains with take.
module ks_sram_rd
  import ks_pkg::*;
#(
  parameter int ADDR_W  = KS_ADDR_W,
  parameter int DATA_W  = KS_DATA_W,
  parameter int RD_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              take,
  input  logic [DATA_W-1:0] sram_dq,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_oe_n,
  output logic [DATA_W-1:0] key,
  output logic              key_vld,
  output logic              cap
);

  localparam logic [3:0] WAIT_LOAD = 4'(RD_WAIT - 1);

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic              key_vld_q, key_vld_d;
  logic              last;
  logic              room;

  assign last = (wait_cnt_q == 4'd0);
  // A finished read parks on its last cycle (oe_n still low) until the key slot frees up.
  assign room = !key_vld_q || take;
  assign cap  = req && last && room;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    key_d      = key_q;
    key_vld_d  = key_vld_q && !take;
    if (!req || cap) begin
      wait_cnt_d = WAIT_LOAD;
    end else if (!last) begin
      wait_cnt_d = wait_cnt_q - 4'd1;
    end
    if (cap) begin
      key_d     = sram_dq;
      key_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= WAIT_LOAD;
      key_q      <= '0;
      key_vld_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      key_q      <= key_d;
      key_vld_q  <= key_vld_d;
    end
  end

  assign sram_addr = addr;
  assign sram_oe_n = req ? SRAM_ASSERT : SRAM_DEASSERT;
  assign key       = key_q;
  assign key_vld   = key_vld_q;

endmodule

// File: rtl/ks_xor_reader.sv
// ks_xor_reader: reads keystream words from SRAM in address order and XORs each with one
// plaintext word. Define KS_PREFETCH_EN to overlap the next SRAM read with the current transfer.
module ks_xor_reader
  import ks_pkg::*;
#(
  parameter int ADDR_W     = KS_ADDR_W,
  parameter int DATA_W     = KS_DATA_W,
  parameter int START_ADDR = 1,
  parameter int NUM_WORDS  = 500,
  parameter int RD_WAIT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  input  logic [DATA_W-1:0] pt_data,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [DATA_W-1:0] ct_data,
  output logic              ct_valid,
  input  logic              ct_ready
);

  localparam int                CNT_W    = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(START_ADDR);

  ks_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] ct_data_q, ct_data_d;
  logic              ct_valid_q, ct_valid_d;

  logic              rd_req, rd_take, rd_cap, rd_key_vld;
  logic [DATA_W-1:0] rd_key;
  logic [DATA_W-1:0] key_use;
  logic              key_use_vld;
  logic              run_start, pt_hs;

`ifdef KS_PREFETCH_EN
  logic [DATA_W-1:0] key_q, key_d;
  logic              key_vld_q, key_vld_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

  // The read engine's register acts as kbuf; key_q is the word offered to plaintext.
  assign key_use     = key_q;
  assign key_use_vld = key_vld_q;
  assign rd_req      = ((state_q == ST_RD_ACC) || (state_q == ST_XFER)) && (rd_cnt_q != LAST_CNT);
  assign rd_take     = rd_key_vld && (!key_vld_q || pt_hs);
`else
  assign key_use     = rd_key;
  assign key_use_vld = rd_key_vld;
  assign rd_req      = (state_q == ST_RD_ACC);
  assign rd_take     = pt_hs;
`endif

  assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign pt_ready  = (state_q == ST_XFER) && key_use_vld && (!ct_valid_q || ct_ready);
  assign pt_hs     = pt_valid && pt_ready;

  ks_sram_rd #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_WAIT (RD_WAIT)
  ) u_sram_rd (
    .clk       (clk),
    .reset     (reset),
    .req       (rd_req),
    .addr      (addr_q),
    .take      (rd_take),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_oe_n (sram_oe_n),
    .key       (rd_key),
    .key_vld   (rd_key_vld),
    .cap       (rd_cap)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
    ct_data_d  = ct_data_q;
    ct_valid_d = ct_valid_q && !ct_ready;
`ifdef KS_PREFETCH_EN
    key_d     = key_q;
    key_vld_d = key_vld_q && !pt_hs;
    rd_cnt_d  = rd_cnt_q;
    if (rd_take) begin
      key_d     = rd_key;
      key_vld_d = 1'b1;
    end
    // Address tracks issued reads so the next word is fetched ahead of its transfer.
    if (rd_cap) begin
      addr_d   = addr_q + 1'b1;
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
`else
    if (pt_hs) begin
      addr_d = addr_q + 1'b1;
    end
`endif
    if (pt_hs) begin
      ct_data_d  = pt_data ^ key_use;
      ct_valid_d = 1'b1;
      word_cnt_d = word_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (run_start) begin
          state_d    = ST_RD_ACC;
          addr_d     = FIRST_A;
          word_cnt_d = '0;
`ifdef KS_PREFETCH_EN
          rd_cnt_d   = '0;
`endif
        end
      end
      ST_RD_ACC: begin
`ifdef KS_PREFETCH_EN
        if (rd_take) state_d = ST_XFER;
`else
        if (rd_cap) state_d = ST_XFER;
`endif
      end
      ST_XFER: begin
        if (pt_hs) begin
          if (word_cnt_d == LAST_CNT) begin
            state_d = ST_DRAIN;
          end else begin
`ifdef KS_PREFETCH_EN
            state_d = ST_XFER;
`else
            state_d = ST_RD_ACC;
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (!ct_valid_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      word_cnt_q <= '0;
      ct_data_q  <= '0;
      ct_valid_q <= 1'b0;
`ifdef KS_PREFETCH_EN
      key_q      <= '0;
      key_vld_q  <= 1'b0;
      rd_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      ct_data_q  <= ct_data_d;
      ct_valid_q <= ct_valid_d;
`ifdef KS_PREFETCH_EN
      key_q      <= key_d;
      key_vld_q  <= key_vld_d;
      rd_cnt_q   <= rd_cnt_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign sram_ce_n = busy ? SRAM_ASSERT : SRAM_DEASSERT;
  assign sram_we_n = SRAM_DEASSERT;
  assign sram_lb_n = SRAM_ASSERT;
  assign sram_ub_n = SRAM_ASSERT;
  assign ct_data   = ct_data_q;
  assign ct_valid  = ct_valid_q;

endmodule

// File: tb/tb_ks_xor_reader.sv
// tb_ks_xor_reader: directed checks of the keystream XOR reader with a 4-word SRAM image.
// Builds with or without KS_PREFETCH_EN; the prefetch build uses RD_WAIT=1.
module tb_ks_xor_reader;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;
  localparam int NUM_WORDS = 4;
`ifdef KS_PREFETCH_EN
  localparam int RD_WAIT = 1;
  localparam int HS_GAP  = 1;
`else
  localparam int RD_WAIT = 2;
  localparam int HS_GAP  = 3;
`endif

  logic              clk = 1'b0;
  logic              reset, start, pt_valid, ct_ready;
  logic [DATA_W-1:0] pt_data;
  logic              busy, done, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
  logic              pt_ready, ct_valid;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq, ct_data;

  logic [15:0] mem [0:7];
  logic [15:0] ct_log [$];
  int          hs_cyc [$];
  int          cyc = 0;
  int          bad_rd = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  assign sram_dq = (sram_addr < 18'd8) ? mem[sram_addr[2:0]] : 16'hDEAD;

  ks_xor_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .START_ADDR (1),
    .NUM_WORDS  (NUM_WORDS),
    .RD_WAIT    (RD_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_lb_n (sram_lb_n),
    .sram_ub_n (sram_ub_n),
    .pt_data   (pt_data),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .ct_data   (ct_data),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1ns after posedge, so the negedge view predicts the next edge's handshake.
  always @(negedge clk) begin
    if (!reset && ct_valid && ct_ready) begin
      ct_log.push_back(ct_data);
      hs_cyc.push_back(cyc);
    end
    if (!reset && !sram_oe_n && (sram_addr == 18'd0 || sram_addr > 18'd4)) bad_rd = bad_rd + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic clear_log();
    ct_log.delete();
    hs_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b0;
    tick(); tick();
    tests_run++;
    if ({busy, done, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, pt_ready, ct_valid} !== 9'b001110000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b want 001110000",
               {busy, done, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, pt_ready, ct_valid});
    end
    tests_run++;
    if (sram_addr !== 18'd0 || ct_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_data: addr %h ct %h want 0 0", sram_addr, ct_data);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if ({busy, done, sram_ce_n} !== 3'b001) begin
      tests_failed++;
      $display("FAIL reset_idle: got %b want 001", {busy, done, sram_ce_n});
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp [4];
    logic [15:0] got;
    bit ok;
    exp = '{16'h12CB, 16'hFF00, 16'h00FF, 16'hA55A};
    clear_log();
    pt_data = 16'h00FF; pt_valid = 1'b1; ct_ready = 1'b1;
    pulse_start();
    tests_run++;
    if ({busy, done, sram_ce_n, sram_oe_n} !== 4'b1000 || sram_addr !== 18'd1) begin
      tests_failed++;
      $display("FAIL basic_launch: ctrl %b addr %0d want 1000 addr 1", {busy, done, sram_ce_n, sram_oe_n}, sram_addr);
    end
    wait_done(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL basic_timeout: done %b want 1", done);
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < ct_log.size()) ? ct_log[i] : 16'hxxxx;
      tests_run++;
      if (got !== exp[i]) begin
        tests_failed++;
        $display("FAIL basic_ct%0d: got %h want %h", i, got, exp[i]);
      end
    end
    tests_run++;
    if (ct_log.size() != 4 || {busy, done, sram_ce_n} !== 3'b011) begin
      tests_failed++;
      $display("FAIL basic_end: words %0d ctrl %b want 4 011", ct_log.size(), {busy, done, sram_ce_n});
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp [4];
    logic [15:0] got;
    logic [17:0] snap_addr;
    bit ok;
    exp = '{16'h1D3B, 16'hF0F0, 16'h0F0F, 16'hAAAA};
    clear_log();
    pt_data = 16'h0F0F; pt_valid = 1'b1; ct_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ct_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!ok || ct_data !== 16'h1D3B) begin
      tests_failed++;
      $display("FAIL bp_first: valid %b ct %h want 1 1d3b", ct_valid, ct_data);
    end
    snap_addr = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) snap_addr = sram_addr;
      tests_run++;
      if ({ct_valid, pt_ready, ct_data} !== {2'b10, 16'h1D3B}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: valid %b ready %b ct %h want 1 0 1d3b", i, ct_valid, pt_ready, ct_data);
      end
      if (i > 4) begin
        tests_run++;
        if (sram_addr !== snap_addr) begin
          tests_failed++;
          $display("FAIL bp_addr%0d: got %h want %h", i, sram_addr, snap_addr);
        end
      end
      tick();
    end
    ct_ready = 1'b1;
    wait_done(ok);
    tests_run++;
    if (!ok || ct_log.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_end: done %b words %0d want 1 4", done, ct_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < ct_log.size()) ? ct_log[i] : 16'hxxxx;
      tests_run++;
      if (got !== exp[i]) begin
        tests_failed++;
        $display("FAIL bp_ct%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp [4];
    logic [15:0] got;
    bit ok;
    exp = '{16'h4761, 16'hAAAA, 16'h5555, 16'hF0F0};
    clear_log();
    pt_data = 16'h5555; pt_valid = 1'b1; ct_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ct_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    repeat (5) tick();
    tests_run++;
    if (!ok || {ct_valid, pt_ready, ct_data} !== {2'b10, 16'h4761}) begin
      tests_failed++;
      $display("FAIL sim_pre: valid %b ready %b ct %h want 1 0 4761", ct_valid, pt_ready, ct_data);
    end
    ct_ready = 1'b1;
    #1;
    tests_run++;
    if (pt_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL sim_ready: got %b want 1", pt_ready);
    end
    tick();
    tests_run++;
    if (ct_valid !== 1'b1 || ct_data !== 16'hAAAA) begin
      tests_failed++;
      $display("FAIL sim_next: valid %b ct %h want 1 aaaa", ct_valid, ct_data);
    end
    wait_done(ok);
    tests_run++;
    if (!ok || ct_log.size() != 4) begin
      tests_failed++;
      $display("FAIL sim_end: done %b words %0d want 1 4", done, ct_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < ct_log.size()) ? ct_log[i] : 16'hxxxx;
      tests_run++;
      if (got !== exp[i]) begin
        tests_failed++;
        $display("FAIL sim_ct%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp [4];
    logic [15:0] got;
    bit ok;
    exp = '{16'h12CB, 16'hFF00, 16'h00FF, 16'hA55A};
    clear_log();
    pt_data = 16'h00FF; pt_valid = 1'b1; ct_ready = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (ct_log.size() >= 2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tests_run++;
    if (!ok || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_reach: words %0d busy %b want 2 1", ct_log.size(), busy);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if ({busy, done, sram_ce_n, sram_oe_n, pt_ready, ct_valid} !== 6'b001100 || sram_addr !== 18'd0 || ct_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL rst_mid_vals: ctrl %b addr %h ct %h want 001100 0 0",
               {busy, done, sram_ce_n, sram_oe_n, pt_ready, ct_valid}, sram_addr, ct_data);
    end
    reset = 1'b0;
    tick();
    clear_log();
    pulse_start();
    tests_run++;
    if (sram_addr !== 18'd1) begin
      tests_failed++;
      $display("FAIL rst_mid_addr: got %0d want 1", sram_addr);
    end
    wait_done(ok);
    tests_run++;
    if (!ok || ct_log.size() != 4) begin
      tests_failed++;
      $display("FAIL rst_mid_end: done %b words %0d want 1 4", done, ct_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < ct_log.size()) ? ct_log[i] : 16'hxxxx;
      tests_run++;
      if (got !== exp[i]) begin
        tests_failed++;
        $display("FAIL rst_mid_ct%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    logic [15:0] exp [4];
    logic [15:0] got;
    bit ok;
    exp = '{16'h12CB, 16'hFF00, 16'h00FF, 16'hA55A};
    pt_data = 16'h00FF; pt_valid = 1'b1; ct_ready = 1'b1;
    for (int run = 0; run < 2; run++) begin
      clear_log();
      pulse_start();
      tests_run++;
      if ({busy, done} !== 2'b10) begin
        tests_failed++;
        $display("FAIL sb_launch%0d: got %b want 10", run, {busy, done});
      end
      if (run == 0) begin
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_done(ok);
      tests_run++;
      if (!ok || ct_log.size() != 4) begin
        tests_failed++;
        $display("FAIL sb_end%0d: done %b words %0d want 1 4", run, done, ct_log.size());
      end
      for (int i = 0; i < 4; i++) begin
        got = (i < ct_log.size()) ? ct_log[i] : 16'hxxxx;
        tests_run++;
        if (got !== exp[i]) begin
          tests_failed++;
          $display("FAIL sb_ct%0d_%0d: got %h want %h", run, i, got, exp[i]);
        end
      end
    end
  endtask

  task automatic test_throughput();
    logic [15:0] exp [4];
    logic [15:0] got;
    int gap;
    bit ok;
    exp = '{16'hEDCB, 16'h0000, 16'hFFFF, 16'h5A5A};
    clear_log();
    pt_data = 16'hFFFF; pt_valid = 1'b1; ct_ready = 1'b1;
    pulse_start();
    wait_done(ok);
    tests_run++;
    if (!ok || ct_log.size() != 4) begin
      tests_failed++;
      $display("FAIL tp_end: done %b words %0d want 1 4", done, ct_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < ct_log.size()) ? ct_log[i] : 16'hxxxx;
      tests_run++;
      if (got !== exp[i]) begin
        tests_failed++;
        $display("FAIL tp_ct%0d: got %h want %h", i, got, exp[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      gap = (i < hs_cyc.size()) ? (hs_cyc[i] - hs_cyc[i-1]) : -1;
      tests_run++;
      if (gap != HS_GAP) begin
        tests_failed++;
        $display("FAIL tp_gap%0d: got %0d want %0d", i, gap, HS_GAP);
      end
    end
  endtask

  task automatic test_no_overread();
    tests_run++;
    if (bad_rd != 0) begin
      tests_failed++;
      $display("FAIL overread: got %0d out-of-range read cycles want 0", bad_rd);
    end
  endtask

  initial begin
    mem[0] = 16'hDEAD; mem[1] = 16'h1234; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
    mem[4] = 16'hA5A5; mem[5] = 16'hBEEF; mem[6] = 16'hC0DE; mem[7] = 16'h7777;
    reset = 1'b1; start = 1'b0; pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_start_busy();
    test_throughput();
    test_no_overread();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
